// File: rtl/dcim_bitserial_ctrl.sv
// Bit-serial sequencer for one OAI column group: streams two activation words MSB-first,
// one row per cycle, and shift-accumulates the returned partial products into a dot product.
module dcim_bitserial_ctrl #(
    parameter int unsigned IN_BITS   = 8,
    parameter int unsigned W_BITS    = 12,
    parameter int unsigned ACC_W     = 22,
    parameter int unsigned SIGNED_IN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_BITS-1:0] in_x0,
    input  logic [IN_BITS-1:0] in_x1,
    output logic               mac_c,
    output logic               mac_d,
    input  logic [W_BITS-1:0]  mac_e,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum
);

    localparam int unsigned BW = $clog2(IN_BITS);
    localparam logic [BW-1:0] MSB_IDX = BW'(IN_BITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
    typedef enum logic {PhA, PhB} phase_e;

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [IN_BITS-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               mac_c_q, mac_c_d, mac_d_q, mac_d_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;

    logic [ACC_W-1:0]   mac_e_ext;
    logic               sub_term;
    logic [BW-1:0]      bit_dec;

    assign mac_e_ext = {{(ACC_W - W_BITS){1'b0}}, mac_e};
    // The MSB of a two's complement activation carries negative weight.
    assign sub_term  = (SIGNED_IN != 0) && (bit_q == MSB_IDX);
    assign bit_dec   = bit_q - 1'b1;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        acc_d       = acc_q;
        bit_d       = bit_q;
        mac_c_d     = mac_c_q;
        mac_d_d     = mac_d_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x0_d    = in_x0;
                    x1_d    = in_x1;
                    acc_d   = '0;
                    bit_d   = MSB_IDX;
                    phase_d = PhA;
                    mac_c_d = ~in_x0[IN_BITS-1];
                    mac_d_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (phase_q == PhA) begin
                    acc_d   = sub_term ? ((acc_q << 1) - mac_e_ext) : ((acc_q << 1) + mac_e_ext);
                    phase_d = PhB;
                    mac_c_d = 1'b1;
                    mac_d_d = ~x1_q[bit_q];
                end else begin
                    acc_d   = sub_term ? (acc_q - mac_e_ext) : (acc_q + mac_e_ext);
                    phase_d = PhA;
                    if (bit_q == '0) begin
                        out_sum_d   = acc_d;
                        out_valid_d = 1'b1;
                        mac_c_d     = 1'b1;
                        mac_d_d     = 1'b1;
                        bit_d       = MSB_IDX;
                        state_d     = StDone;
                    end else begin
                        bit_d   = bit_dec;
                        mac_c_d = ~x0_q[bit_dec];
                        mac_d_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort wins over any handshake; the pending result is dropped but out_sum is kept.
        if (soft_clr) begin
            state_d     = StIdle;
            phase_d     = PhA;
            acc_d       = '0;
            bit_d       = MSB_IDX;
            mac_c_d     = 1'b1;
            mac_d_d     = 1'b1;
            out_valid_d = 1'b0;
            out_sum_d   = out_sum_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= PhA;
            x0_q        <= '0;
            x1_q        <= '0;
            acc_q       <= '0;
            bit_q       <= MSB_IDX;
            mac_c_q     <= 1'b1;
            mac_d_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            acc_q       <= acc_d;
            bit_q       <= bit_d;
            mac_c_q     <= mac_c_d;
            mac_d_q     <= mac_d_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign mac_c     = mac_c_q;
    assign mac_d     = mac_d_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_dcim_bitserial_ctrl.sv
// Drives an unsigned and a signed controller in lockstep against a behavioural OAI cell model;
// a scoreboard queue holds expected dot products, popped by an independent monitor.
module tb_dcim_bitserial_ctrl;

    localparam int unsigned IN_BITS = 8;
    localparam int unsigned W_BITS  = 12;
    localparam int unsigned ACC_W   = 22;
    localparam longint      MASK    = (64'sd1 <<< ACC_W) - 1;

    logic clk = 1'b0;
    logic rst_n, soft_clr, in_valid, out_ready;
    logic [IN_BITS-1:0] in_x0, in_x1;
    logic [W_BITS-1:0]  w0, w1;
    logic [1:0] in_ready, mac_c, mac_d, busy, out_valid;
    logic [1:0][W_BITS-1:0] mac_e;
    logic [1:0][ACC_W-1:0]  out_sum;

    typedef struct {
        longint eu;
        longint es;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit rdy_mode = 1'b0;

    always #5 clk = ~clk;

    dcim_bitserial_ctrl #(.IN_BITS(IN_BITS), .W_BITS(W_BITS), .ACC_W(ACC_W), .SIGNED_IN(0))
    u_dut_u (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_ready(in_ready[0]), .in_x0(in_x0), .in_x1(in_x1), .mac_c(mac_c[0]),
        .mac_d(mac_d[0]), .mac_e(mac_e[0]), .busy(busy[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_sum(out_sum[0])
    );

    dcim_bitserial_ctrl #(.IN_BITS(IN_BITS), .W_BITS(W_BITS), .ACC_W(ACC_W), .SIGNED_IN(1))
    u_dut_s (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid),
        .in_ready(in_ready[1]), .in_x0(in_x0), .in_x1(in_x1), .mac_c(mac_c[1]),
        .mac_d(mac_d[1]), .mac_e(mac_e[1]), .busy(busy[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_sum(out_sum[1])
    );

    // OAI cell model: a selected row (active-low input) returns its weight.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            mac_e[g] = '0;
            if (!mac_c[g]) mac_e[g] = mac_e[g] | w0;
            if (!mac_d[g]) mac_e[g] = mac_e[g] | w1;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint model(input bit sgn, input logic [IN_BITS-1:0] a,
                                     input logic [IN_BITS-1:0] b, input int wa, input int wb);
        longint va = longint'(a);
        longint vb = longint'(b);
        if (sgn && a[IN_BITS-1]) va = va - (64'sd1 <<< IN_BITS);
        if (sgn && b[IN_BITS-1]) vb = vb - (64'sd1 <<< IN_BITS);
        return (va * wa + vb * wb) & MASK;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = 1'($urandom_range(1));
        end
    end

    // Monitor: invariants, latency, hold-under-backpressure and scoreboard pops.
    initial begin
        int     lat = 0;
        int     run_cnt = 0;
        bit     lat_on = 1'b0;
        bit     pv = 1'b0;
        bit     pr = 1'b0;
        longint ps0 = 0;
        longint ps1 = 0;
        exp_t   e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lat_on = 1'b0;
                pv = 1'b0;
                run_cnt = 0;
                continue;
            end
            for (int g = 0; g < 2; g++) begin
                check("mac_not_both_low", longint'(mac_c[g] | mac_d[g]), 1);
                if (!busy[g]) check("mac_high_outside_run", longint'(mac_c[g] & mac_d[g]), 1);
            end
            if (lat_on) lat++;
            if (out_valid[0] && !pv) begin
                check("latency_edges", lat, 2 * IN_BITS + 1);
                check("run_cycles", run_cnt, 2 * IN_BITS);
                lat_on = 1'b0;
            end
            if (pv && !pr) begin
                check("hold_valid", longint'(out_valid[0]), 1);
                check("hold_sum_u", longint'(out_sum[0]), ps0);
                check("hold_sum_s", longint'(out_sum[1]), ps1);
                check("hold_in_ready", longint'(in_ready[0]), 0);
            end
            if (in_ready[0]) run_cnt = 0;
            else if (busy[0]) run_cnt++;
            if (out_valid[0] && out_ready && !soft_clr) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got %0d expected no result", out_sum[0]);
                end else begin
                    e = exp_q.pop_front();
                    check("sum_unsigned", longint'(out_sum[0]), e.eu);
                    check("sum_signed", longint'(out_sum[1]), e.es);
                    check("valid_lockstep", longint'(out_valid[1]), 1);
                end
            end
            if (in_valid && in_ready[0] && !soft_clr) begin
                lat_on = 1'b1;
                lat = 0;
            end
            pv  = out_valid[0];
            pr  = out_ready;
            ps0 = longint'(out_sum[0]);
            ps1 = longint'(out_sum[1]);
        end
    end

    task automatic issue(input logic [IN_BITS-1:0] a, input logic [IN_BITS-1:0] b,
                         input int wa, input int wb, input bit push,
                         input longint eu, input longint es, output int t);
        int n = 0;
        while (!in_ready[0] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", longint'(in_ready[0]), 1);
        w0 = W_BITS'(wa);
        w1 = W_BITS'(wb);
        in_x0 = a;
        in_x1 = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back('{eu: eu, es: es});
        t = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_x0 = IN_BITS'($urandom);
        in_x1 = IN_BITS'($urandom);
    endtask

    task automatic issue_rand(output int t);
        logic [IN_BITS-1:0] a, b;
        int wa, wb;
        a  = IN_BITS'($urandom);
        b  = IN_BITS'($urandom);
        wa = int'($urandom_range(4095));
        wb = int'($urandom_range(4095));
        issue(a, b, wa, wb, 1'b1, model(1'b0, a, b, wa, wb), model(1'b1, a, b, wa, wb), t);
    endtask

    task automatic check_idle_outputs(input string tag, input longint su, input longint ss);
        check({tag, "_in_ready"}, longint'(in_ready), 3);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_mac_c"}, longint'(mac_c), 3);
        check({tag, "_mac_d"}, longint'(mac_d), 3);
        check({tag, "_out_sum_u"}, longint'(out_sum[0]), su);
        check({tag, "_out_sum_s"}, longint'(out_sum[1]), ss);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready[0]) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int t1, t2, t3, n;
        rst_n = 1'b0;
        soft_clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_x0 = '0;
        in_x1 = '0;
        w0 = '0;
        w1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset", 0, 0);
        rst_n = 1'b1;

        // Directed arithmetic cases (unsigned / signed expectations per pair).
        issue(8'd5, 8'd7, 100, 3, 1'b1, 521, 521, t1);
        issue(8'hFF, 8'h02, 100, 3, 1'b1, 25506, 22'h3FFFA2, t1);
        issue(8'hFF, 8'hFF, 4095, 4095, 1'b1, 2088450, 22'h3FE002, t1);
        issue(8'h80, 8'h80, 4095, 4095, 1'b1, 1048320, 22'h300100, t1);
        issue(8'h00, 8'h01, 4095, 17, 1'b1, 17, 17, t1);
        drain();

        // Back-to-back throughput with out_ready held high.
        issue_rand(t1);
        issue_rand(t2);
        issue_rand(t3);
        check("b2b_interval_1", t2 - t1, 2 * IN_BITS + 2);
        check("b2b_interval_2", t3 - t2, 2 * IN_BITS + 2);
        drain();

        // Backpressure: result must hold for 5 cycles, in_ready returns one cycle after release.
        out_ready = 1'b0;
        issue(8'd9, 8'hF0, 1234, 567, 1'b1, model(1'b0, 8'd9, 8'hF0, 1234, 567),
              model(1'b1, 8'd9, 8'hF0, 1234, 567), t1);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_result_seen", longint'(out_valid[0]), 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_in_ready_low", longint'(in_ready[0]), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released_in_ready", longint'(in_ready[0]), 1);
        check("bp_released_valid", longint'(out_valid[0]), 0);

        // soft_clr in RUN cycle 6 together with in_valid: aborted, no result, out_sum kept.
        issue(8'd33, 8'd44, 55, 66, 1'b0, 0, 0, t1);
        repeat (5) @(posedge clk);
        #1;
        soft_clr = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        soft_clr = 1'b0;
        in_valid = 1'b0;
        check_idle_outputs("abort", model(1'b0, 8'd9, 8'hF0, 1234, 567),
                           model(1'b1, 8'd9, 8'hF0, 1234, 567));
        issue(8'd12, 8'hC3, 2047, 4000, 1'b1, model(1'b0, 8'd12, 8'hC3, 2047, 4000),
              model(1'b1, 8'd12, 8'hC3, 2047, 4000), t1);
        drain();

        // Asynchronous reset mid-RUN: outputs return to reset values without a clock edge.
        issue(8'd77, 8'd88, 99, 111, 1'b0, 0, 0, t1);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset", 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(8'hA5, 8'h5A, 3000, 1500, 1'b1, model(1'b0, 8'hA5, 8'h5A, 3000, 1500),
              model(1'b1, 8'hA5, 8'h5A, 3000, 1500), t1);
        drain();

        // Randomised pairs under random consumer backpressure.
        rdy_mode = 1'b1;
        repeat (25) issue_rand(t1);
        #20;
        rdy_mode = 1'b0;
        #1;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
